// File: rtl/inst_encoder_loader_pkg.sv
// rtl/inst_encoder_loader_pkg.sv - shared kind codes, opcodes, state encodings and helpers
package inst_encoder_loader_pkg;

    // Request kinds; codes 9..15 are undefined and always dropped
    localparam logic [3:0] KIND_R      = 4'd0;
    localparam logic [3:0] KIND_I      = 4'd1;
    localparam logic [3:0] KIND_SHAMT  = 4'd2;
    localparam logic [3:0] KIND_LOAD   = 4'd3;
    localparam logic [3:0] KIND_STORE  = 4'd4;
    localparam logic [3:0] KIND_BRANCH = 4'd5;
    localparam logic [3:0] KIND_LUI    = 4'd6;
    localparam logic [3:0] KIND_JAL    = 4'd7;
    localparam logic [3:0] KIND_JALR   = 4'd8;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Loader FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // True when v is representable as an n-bit two's complement value:
    // bits [31:n-1] must all equal the sign bit.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned n);
        logic [31:0] hi_mask;
        hi_mask = 32'hFFFF_FFFF << (n - 1);
        return ((v & hi_mask) == 32'd0) || ((v & hi_mask) == hi_mask);
    endfunction

endpackage

// File: rtl/rv_inst_pack.sv
// rtl/rv_inst_pack.sv - combinational RV32I field packer with legality check
module rv_inst_pack
    import inst_encoder_loader_pkg::*;
(
    input  logic [3:0]  i_kind,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_legal
);

    // Pack fields into the instruction format selected by kind and judge the immediate range
    always_comb begin
        o_word  = 32'd0;
        o_legal = 1'b0;
        case (i_kind)
            KIND_R: begin
                o_word  = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OPC_OP};
                o_legal = 1'b1;
            end
            KIND_I: begin
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_IMM};
                o_legal = fits_signed(i_imm, 12);
            end
            KIND_SHAMT: begin
                o_word  = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, OPC_IMM};
                o_legal = (i_imm[31:5] == 27'd0);
            end
            KIND_LOAD: begin
                o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OPC_LOAD};
                o_legal = fits_signed(i_imm, 12);
            end
            KIND_JALR: begin
                o_word  = {i_imm[11:0], i_rs1, 3'b000, i_rd, OPC_JALR};
                o_legal = fits_signed(i_imm, 12);
            end
            KIND_STORE: begin
                o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OPC_STORE};
                o_legal = fits_signed(i_imm, 12);
            end
            KIND_BRANCH: begin
                o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                           i_imm[4:1], i_imm[11], OPC_BRANCH};
                o_legal = fits_signed(i_imm, 13) && !i_imm[0];
            end
            KIND_LUI: begin
                o_word  = {i_imm[31:12], i_rd, OPC_LUI};
                o_legal = (i_imm[11:0] == 12'd0);
            end
            KIND_JAL: begin
                o_word  = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, OPC_JAL};
                o_legal = fits_signed(i_imm, 21) && !i_imm[0];
            end
            default: begin
                o_word  = 32'd0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// rtl/inst_encoder_loader.sv - streams encoded RV32I words into instruction memory
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int AW    = 10,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    input  logic             in_last,
    output logic             im_we,
    input  logic             im_ready,
    output logic [AW-1:0]    im_addr,
    output logic [31:0]      im_wdata,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [AW-1:0]    ADDR_STEP = AW'(4);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_accept;
    logic        w_complete;
    logic        w_start;
    logic        w_unused_base;

    rv_inst_pack u_pack (
        .i_kind   (in_kind),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_imm    (in_imm),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    // A new request may enter whenever the single output slot is empty or emptying this edge
    assign in_ready      = (r_state == ST_RUN) && (!r_we || im_ready);
    assign w_accept      = in_valid && in_ready;
    assign w_complete    = r_we && im_ready;
    assign w_start       = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_unused_base = &{1'b0, base_addr[1:0]};

    assign im_we    = r_we;
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done     = (r_state == ST_DONE);
    assign word_cnt = r_word_cnt;
    assign err_cnt  = r_err_cnt;

    // Control FSM: run until the last request is taken, then wait for the output slot to drain
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start) r_state <= ST_RUN;
                ST_RUN:   if (w_accept && in_last) r_state <= ST_DRAIN;
                ST_DRAIN: if (!r_we || w_complete) r_state <= ST_DONE;
                ST_DONE:  if (start) r_state <= ST_RUN;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Output slot: load a legal word on accept, release it when memory takes it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
        end else if (w_accept && w_legal) begin
            r_we    <= 1'b1;
            r_wdata <= w_word;
        end else if (w_complete) begin
            r_we    <= 1'b0;
        end
    end

    // Address of the slot word and saturating word/error counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_addr     <= '0;
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_start) begin
            r_addr     <= {base_addr[AW-1:2], 2'b00};
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_complete) begin
                r_addr <= r_addr + ADDR_STEP;
                if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + CNT_ONE;
            end
            if (w_accept && !w_legal && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb/tb_inst_encoder_loader.sv - self-checking bench for inst_encoder_loader
module tb_inst_encoder_loader;

    localparam int AW    = 10;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [AW-1:0]    base_addr;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_kind;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [31:0]      in_imm;
    logic             in_last;
    logic             im_we;
    logic             im_ready;
    logic [AW-1:0]    im_addr;
    logic [31:0]      im_wdata;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+31:0] got_q[$];
    logic [AW+31:0] exp_q[$];
    logic [AW-1:0]  exp_addr;
    int             exp_err;
    bit             stop_toggle;

    inst_encoder_loader #(.AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Record every write that memory takes at the coming rising edge
    always @(negedge clk) begin
        if (rstn === 1'b1 && im_we === 1'b1 && im_ready === 1'b1) got_q.push_back({im_addr, im_wdata});
    end

    // Reference encoder: signed range checks on the integer value, fields placed by shifting
    function automatic void ref_encode(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm, output logic [31:0] w, output bit ok);
        int s;
        logic [31:0] base;
        s    = imm;
        base = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
        w    = 32'd0;
        ok   = 1'b0;
        case (k)
            4'd0: begin ok = 1; w = (32'(f7) << 25) | (32'(rs2) << 20) | base | 32'h33; end
            4'd1: begin ok = (s >= -2048 && s <= 2047); w = ((imm & 32'hFFF) << 20) | base | 32'h13; end
            4'd2: begin ok = (imm < 32); w = (32'(f7) << 25) | ((imm & 32'h1F) << 20) | base | 32'h13; end
            4'd3: begin ok = (s >= -2048 && s <= 2047); w = ((imm & 32'hFFF) << 20) | base | 32'h03; end
            4'd8: begin
                ok = (s >= -2048 && s <= 2047);
                w  = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h67;
            end
            4'd4: begin
                ok = (s >= -2048 && s <= 2047);
                w  = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'h23;
            end
            4'd5: begin
                ok = (s >= -4096 && s <= 4095) && (s % 2 == 0);
                w  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                   | (32'(rs1) << 15) | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 1) << 7) | 32'h63;
            end
            4'd6: begin ok = ((imm % 4096) == 0); w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h37; end
            4'd7: begin
                ok = (s >= -1048576 && s <= 1048575) && (s % 2 == 0);
                w  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                   | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'h6F;
            end
            default: begin ok = 0; w = 32'd0; end
        endcase
    endfunction

    task automatic start_run(input logic [AW-1:0] b);
        base_addr = b;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        got_q.delete();
        exp_q.delete();
        exp_addr  = {b[AW-1:2], 2'b00};
        exp_err   = 0;
    endtask

    task automatic drive_req(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm, input logic last);
        logic [31:0] w;
        bit ok;
        int n;
        ref_encode(k, f3, f7, rd, rs1, rs2, imm, w, ok);
        if (ok) begin
            exp_q.push_back({exp_addr, w});
            exp_addr = exp_addr + AW'(4);
        end else begin
            exp_err++;
        end
        in_kind = k; in_funct3 = f3; in_funct7 = f7; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_last = last; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL accept_timeout: in_ready=%b required 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL done_timeout: done=%b required 1", done); end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0; im_ready = 1'b1;
        in_kind = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready, im_we, busy, done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: {in_ready,im_we,busy,done}=%b required 0000", {in_ready, im_we, busy, done});
        end
        n_checks++;
        if (im_addr !== '0 || im_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_im: addr=%h wdata=%h required 0/0", im_addr, im_wdata);
        end
        n_checks++;
        if (word_cnt !== '0 || err_cnt !== '0) begin
            n_fail++; $display("FAIL reset_cnt: word_cnt=%0d err_cnt=%0d required 0/0", word_cnt, err_cnt);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        start_run(10'h100);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: busy=%b required 1", busy); end
        drive_req(4'd0, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        n_checks++;
        if (im_we !== 1'b1 || im_addr !== 10'h100 || im_wdata !== 32'h002081B3) begin
            n_fail++; $display("FAIL single_word: we=%b addr=%h data=%h required 1/100/002081b3", im_we, im_addr, im_wdata);
        end
        wait_done();
        n_checks++;
        if (word_cnt !== 8'd1 || err_cnt !== 8'd0 || got_q.size() != 1) begin
            n_fail++; $display("FAIL single_cnt: word_cnt=%0d err_cnt=%0d writes=%0d required 1/0/1", word_cnt, err_cnt, got_q.size());
        end
    endtask

    task automatic test_stream();
        logic [31:0] words[5];
        words = '{32'h00500093, 32'h0020A423, 32'h00208463, 32'h010000EF, 32'h123452B7};
        start_run(10'h000);
        drive_req(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        drive_req(4'd4, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        drive_req(4'd5, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        drive_req(4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0);
        drive_req(4'd6, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        wait_done();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== {AW'(i * 4), words[i]}) begin
                n_fail++; $display("FAIL stream_word%0d: got %h required %h", i,
                                   (i < got_q.size()) ? got_q[i] : '0, {AW'(i * 4), words[i]});
            end
        end
        n_checks++;
        if (word_cnt !== 8'd5 || got_q.size() != 5 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stream_cnt: word_cnt=%0d writes=%0d busy=%b required 5/5/0", word_cnt, got_q.size(), busy);
        end
    endtask

    task automatic test_backpressure();
        logic [AW+31:0] hold;
        start_run(10'h040);
        drive_req(4'd0, 3'd7, 7'h20, 5'd9, 5'd10, 5'd11, 32'd0, 1'b0);
        im_ready = 1'b0;
        hold = {im_addr, im_wdata};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0 || im_we !== 1'b1 || {im_addr, im_wdata} !== hold) begin
                n_fail++; $display("FAIL stall_cycle%0d: in_ready=%b we=%b word=%h required 0/1/%h", c, in_ready, im_we, {im_addr, im_wdata}, hold);
            end
        end
        @(posedge clk); #1;
        im_ready = 1'b1;
        drive_req(4'd3, 3'd2, 7'd0, 5'd4, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b0);
        drive_req(4'd2, 3'd1, 7'd0, 5'd6, 5'd6, 5'd0, 32'd31, 1'b1);
        wait_done();
        n_checks++;
        if (got_q != exp_q) begin
            n_fail++; $display("FAIL stall_words: writes=%0d required %0d or content differs", got_q.size(), exp_q.size());
        end
        n_checks++;
        if (word_cnt !== 8'd3) begin n_fail++; $display("FAIL stall_cnt: word_cnt=%0d required 3", word_cnt); end
    endtask

    task automatic test_drops();
        start_run(10'h040);
        drive_req(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        drive_req(4'd5, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd5, 1'b0);
        drive_req(4'd6, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h00001001, 1'b1);
        wait_done();
        n_checks++;
        if (err_cnt !== 8'd3 || word_cnt !== 8'd0 || got_q.size() != 0) begin
            n_fail++; $display("FAIL drops_cnt: err_cnt=%0d word_cnt=%0d writes=%0d required 3/0/0", err_cnt, word_cnt, got_q.size());
        end
        n_checks++;
        if (im_addr !== 10'h040) begin n_fail++; $display("FAIL drops_addr: im_addr=%h required 040", im_addr); end
    endtask

    task automatic test_wrap();
        start_run(10'h3FE);
        drive_req(4'd1, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'd1, 1'b0);
        drive_req(4'd1, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'hFFFF_F800, 1'b1);
        wait_done();
        n_checks++;
        if (got_q.size() != 2 || got_q[0][AW+31:32] !== 10'h3FC || got_q[1][AW+31:32] !== 10'h000) begin
            n_fail++; $display("FAIL wrap_addr: writes=%0d first=%h second=%h required 3fc/000", got_q.size(),
                               (got_q.size() > 0) ? got_q[0][AW+31:32] : '0, (got_q.size() > 1) ? got_q[1][AW+31:32] : '0);
        end
        n_checks++;
        if (got_q != exp_q) begin n_fail++; $display("FAIL wrap_words: content differs from model"); end
    endtask

    task automatic test_reset_mid();
        start_run(10'h020);
        im_ready = 1'b0;
        drive_req(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready, im_we, busy, done} !== 4'b0000 || im_addr !== '0 || im_wdata !== 32'd0
            || word_cnt !== '0 || err_cnt !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: flags=%b addr=%h data=%h cnt=%0d/%0d required all zero",
                               {in_ready, im_we, busy, done}, im_addr, im_wdata, word_cnt, err_cnt);
        end
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL midreset_nowrite: writes=%0d required 0", got_q.size()); end
        rstn = 1'b1;
        im_ready = 1'b1;
        start_run(10'h080);
        drive_req(4'd8, 3'd5, 7'd0, 5'd1, 5'd3, 5'd0, 32'hFFFF_FFF0, 1'b1);
        wait_done();
        n_checks++;
        if (got_q != exp_q || got_q.size() != 1 || got_q[0][AW+31:32] !== 10'h080) begin
            n_fail++; $display("FAIL midreset_resume: writes=%0d required 1 at 080", got_q.size());
        end
    endtask

    task automatic test_random();
        logic [3:0]  k;
        logic [31:0] imm;
        for (int run = 0; run < 3; run++) begin
            start_run(AW'($urandom));
            stop_toggle = 1'b0;
            fork
                begin
                    for (int r = 0; r < 40; r++) begin
                        k = ($urandom_range(0, 15) == 0) ? 4'(9 + $urandom_range(0, 6)) : 4'($urandom_range(0, 8));
                        case ($urandom_range(0, 4))
                            0: imm = 32'($urandom_range(0, 63));
                            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                            2: imm = $urandom & 32'hFFFF_F000;
                            3: imm = $urandom;
                            default: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
                        endcase
                        drive_req(k, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, r == 39);
                    end
                    wait_done();
                    stop_toggle = 1'b1;
                end
                begin
                    while (!stop_toggle) begin
                        @(posedge clk); #1;
                        im_ready = ($urandom_range(0, 3) != 0);
                    end
                end
            join
            im_ready = 1'b1;
            n_checks++;
            if (got_q != exp_q) begin
                n_fail++; $display("FAIL random%0d_words: writes=%0d required %0d or content differs", run, got_q.size(), exp_q.size());
            end
            n_checks++;
            if (word_cnt !== CNT_W'(exp_q.size()) || err_cnt !== CNT_W'(exp_err)) begin
                n_fail++; $display("FAIL random%0d_cnt: word_cnt=%0d err_cnt=%0d required %0d/%0d", run, word_cnt, err_cnt, exp_q.size(), exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_drops();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
